pipe_stage_skid_reg: RTL and testbench
======================================

Name: pipe_stage_skid_reg

Overview:
Parametrised successor to the fixed 64-bit inter-stage pipeline latch. It is a pipeline stage register with a valid/ready handshake and a 2-entry skid buffer. It also provides flush (bubble insertion), a debug step-enable freeze and a saturating back-pressure counter. It sits between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and is instantiated with stage-specific width.

Parameters:
DATA_W, 64, payload width in bits.
BUBBLE_VAL, 0, value driven on out_data when the stage holds no valid entry (zero-extended/truncated to DATA_W).
CNT_W, 16, width of the stall counter.
CLK_NEG, 1, 1 = all state updates on falling edge of clk; 0 = rising edge.

Ports:
clk  in  1  stage clock; active edge selected by CLK_NEG.
reset  in  1  synchronous, active-low reset.
db_en  in  1  debug step enable; 0 freezes all state.
flush  in  1  discard all held entries on the next active edge.
in_valid  in  1  upstream offers in_data.
in_ready  out  1  stage can accept an entry.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  out_data holds a valid entry.
out_ready  in  1  downstream accepts out_data.
out_data  out  DATA_W  head entry payload, or BUBBLE_VAL when empty.
occupancy  out  2  number of held entries (0..2).
stall_cnt  out  CNT_W  cycles spent back-pressured, saturating.

Behaviour:
- State: main register (main_v, main_d) and skid register (skid_v, skid_d). All state is sampled only on the active edge.
- Reset: reset==0 at an active edge clears main_v, skid_v, both data registers (to BUBBLE_VAL) and stall_cnt. After reset: out_valid=0, out_data=BUBBLE_VAL, occupancy=0, in_ready=1 (provided db_en=1), stall_cnt=0. Reset overrides flush and db_en. Reset asserted mid-transfer drops all entries.
- in_ready = db_en & ~skid_v. out_valid = db_en & main_v. Both are combinational from registered state.
- out_data = main_d when main_v, else BUBBLE_VAL, independent of db_en.
- occupancy = main_v + skid_v. Invariant: skid_v implies main_v.
- Accept event: in_valid & in_ready. Pop event: out_valid & out_ready.
- Latency: an entry accepted into an empty stage appears on out_valid/out_data after exactly 1 active edge. There is no combinational in-to-out path.
- Transitions when db_en=1, flush=0:
  - Empty, accept: main <= in.
  - Main only, accept + pop: main <= in.
  - Main only, accept, no pop: skid <= in; in_ready falls next cycle.
  - Main only, pop, no accept: main_v <= 0.
  - Main+skid, pop: main <= skid, skid_v <= 0. No accept is possible because in_ready=0.
  - Main+skid, no pop: hold.
- Ordering is strictly FIFO: no entry is lost or duplicated while flush=0.
- Flush (reset=1, db_en=1, flush=1): main_v and skid_v are cleared and data is set to BUBBLE_VAL. An accept in the same cycle is discarded. A pop in the same cycle still completes from downstream's view, since the entry was presented. stall_cnt is unchanged.
- Freeze (db_en=0): no state changes, including stall_cnt. in_ready=0 and out_valid=0, so no handshake completes. flush is ignored while frozen.
- stall_cnt increments by 1 on every active edge with db_en=1 and main_v & ~out_ready. It saturates at 2^CNT_W-1 and never wraps. It is cleared only by reset.
- Data registers are loaded only on accept or skid-to-main move. When not loaded they hold their value, with no X propagation.

Test Plan:
- Reset: hold reset=0 for 2 edges with in_valid=1, in_data=0xAA -> out_valid=0, out_data=0, occupancy=0, stall_cnt=0. Release -> in_ready=1.
- Streaming: out_ready=1, push 0x1,0x2,0x3 on consecutive edges -> out_data is 0x1,0x2,0x3 one edge later each, occupancy stays 1, in_ready stays 1.
- Skid: out_ready=0, push 0x10 then 0x20 -> occupancy=2, in_ready=0, stall_cnt increments each edge. Raise out_ready -> 0x10 then 0x20 pop in order, then in_ready=1.
- Flush: stage holds 0x10,0x20; assert flush with in_valid=1, in_data=0x30 -> next edge occupancy=0, out_data=BUBBLE_VAL, 0x30 not stored.
- Freeze: with 0x55 in main, drive db_en=0 for 3 edges with flush=1 and out_ready=1 -> out_valid=0, in_ready=0, no pop, stall_cnt unchanged. Restore db_en=1 -> 0x55 presented again.
- Saturation: CNT_W=4, out_ready=0 for 20 edges with main_v=1 -> stall_cnt stops at 15 and stays at 15.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register: valid/ready handshake with a 2-entry skid buffer, flush,
// debug freeze and a saturating back-pressure counter. Active edge is set by CLK_NEG.
//
// state ({main_v,skid_v}) | meaning
// 2'b00                   | empty, in_ready high
// 2'b10                   | main holds head entry, in_ready high
// 2'b11                   | main + skid full, in_ready low
// 2'b01                   | unreachable, recovers to empty
module pipe_stage_skid_reg #(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int                CNT_W      = 16,
  parameter bit                CLK_NEG    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              db_en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              main_v, skid_v;
  logic [DATA_W-1:0] main_d, skid_d;
  logic [CNT_W-1:0]  stall_q;

  logic              main_v_n, skid_v_n;
  logic [DATA_W-1:0] main_d_n, skid_d_n;
  logic [CNT_W-1:0]  stall_n;

  logic accept, pop;

  assign in_ready  = db_en & ~skid_v;
  assign out_valid = db_en & main_v;
  assign out_data  = main_v ? main_d : BUBBLE_VAL;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
  assign stall_cnt = stall_q;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    main_v_n = main_v;
    skid_v_n = skid_v;
    main_d_n = main_d;
    skid_d_n = skid_d;
    stall_n  = stall_q;

    if (!reset) begin
      main_v_n = 1'b0;
      skid_v_n = 1'b0;
      main_d_n = BUBBLE_VAL;
      skid_d_n = BUBBLE_VAL;
      stall_n  = '0;
    end else if (db_en) begin
      if (main_v && !out_ready && (stall_q != CNT_MAX)) begin
        stall_n = stall_q + 1'b1;
      end

      if (flush) begin
        // a same-cycle pop still completes downstream; the accept is dropped
        main_v_n = 1'b0;
        skid_v_n = 1'b0;
        main_d_n = BUBBLE_VAL;
        skid_d_n = BUBBLE_VAL;
      end else begin
        unique case ({main_v, skid_v})
          2'b00: begin
            if (accept) begin
              main_v_n = 1'b1;
              main_d_n = in_data;
            end
          end
          2'b10: begin
            if (accept && pop) begin
              main_d_n = in_data;
            end else if (accept) begin
              skid_v_n = 1'b1;
              skid_d_n = in_data;
            end else if (pop) begin
              main_v_n = 1'b0;
            end
          end
          2'b11: begin
            if (pop) begin
              main_d_n = skid_d;
              skid_v_n = 1'b0;
            end
          end
          default: begin
            main_v_n = 1'b0;
            skid_v_n = 1'b0;
          end
        endcase
      end
    end
  end

  generate
    if (CLK_NEG) begin : g_neg_edge
      always_ff @(negedge clk) begin
        main_v  <= main_v_n;
        skid_v  <= skid_v_n;
        main_d  <= main_d_n;
        skid_d  <= skid_d_n;
        stall_q <= stall_n;
      end
    end else begin : g_pos_edge
      always_ff @(posedge clk) begin
        main_v  <= main_v_n;
        skid_v  <= skid_v_n;
        main_d  <= main_d_n;
        skid_d  <= skid_d_n;
        stall_q <= stall_n;
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_stage_skid_reg;

  localparam int          DATA_W = 16;
  localparam int          CNT_W  = 4;
  localparam logic [15:0] BUBBLE = 16'hB0B0;
  localparam int          SMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              db_en = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [15:0] q[$];
  int          m_stall = 0;

  pipe_stage_skid_reg #(
    .DATA_W(DATA_W), .BUBBLE_VAL(BUBBLE), .CNT_W(CNT_W), .CLK_NEG(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .db_en(db_en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Model: the stage is a FIFO of at most two entries, advanced on the falling edge.
  always @(negedge clk) begin
    bit acc, pp;
    if (!reset) begin
      q.delete();
      m_stall = 0;
    end else if (db_en) begin
      if (q.size() > 0 && !out_ready && m_stall < SMAX) m_stall++;
      pp  = (q.size() > 0) && out_ready;
      acc = in_valid && (q.size() < 2);
      if (flush) q.delete();
      else begin
        if (pp) void'(q.pop_front());
        if (acc) q.push_back(in_data);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (chk_en) begin
      chk("m_out_valid", 32'(out_valid), 32'(db_en && q.size() > 0));
      chk("m_in_ready",  32'(in_ready),  32'(db_en && q.size() < 2));
      chk("m_out_data",  32'(out_data),  32'((q.size() > 0) ? q[0] : BUBBLE));
      chk("m_occupancy", 32'(occupancy), 32'(q.size()));
      chk("m_stall_cnt", 32'(stall_cnt), 32'(m_stall));
    end
  end

  // Drive one cycle's inputs just after the rising edge; return after the next rising
  // edge, by which time the falling active edge has consumed them.
  task automatic cyc(input bit iv, input logic [15:0] d, input bit ordy,
                     input bit fl, input bit de);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    db_en     = de;
    @(posedge clk);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b1; in_data = 16'h00AA;
    @(posedge clk);
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data),  32'(BUBBLE));
    chk("rst_occupancy", 32'(occupancy), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    #1 reset = 1'b1;
    cyc(0, 0, 1, 0, 1);
    chk("rel_in_ready", 32'(in_ready), 1);

    // streaming
    cyc(1, 16'h1, 1, 0, 1);
    chk("str1_data", 32'(out_data), 1); chk("str1_occ", 32'(occupancy), 1);
    cyc(1, 16'h2, 1, 0, 1);
    chk("str2_data", 32'(out_data), 2); chk("str2_rdy", 32'(in_ready), 1);
    cyc(1, 16'h3, 1, 0, 1);
    chk("str3_data", 32'(out_data), 3); chk("str3_occ", 32'(occupancy), 1);
    cyc(0, 0, 1, 0, 1);
    chk("str_drain_occ", 32'(occupancy), 0);

    // skid
    cyc(1, 16'h10, 0, 0, 1);
    cyc(1, 16'h20, 0, 0, 1);
    chk("skid_occ", 32'(occupancy), 2); chk("skid_rdy", 32'(in_ready), 0);
    chk("skid_stall1", 32'(stall_cnt), 1);
    cyc(0, 0, 0, 0, 1);
    chk("skid_stall2", 32'(stall_cnt), 2); chk("skid_head", 32'(out_data), 16'h10);
    cyc(0, 0, 1, 0, 1);
    chk("skid_pop1_data", 32'(out_data), 16'h20); chk("skid_pop1_occ", 32'(occupancy), 1);
    cyc(0, 0, 1, 0, 1);
    chk("skid_pop2_occ", 32'(occupancy), 0); chk("skid_pop2_rdy", 32'(in_ready), 1);

    // flush
    cyc(1, 16'h10, 0, 0, 1);
    cyc(1, 16'h20, 0, 0, 1);
    chk("fl_pre_occ", 32'(occupancy), 2); chk("fl_pre_stall", 32'(stall_cnt), 3);
    cyc(1, 16'h30, 1, 1, 1);
    chk("fl_occ", 32'(occupancy), 0); chk("fl_data", 32'(out_data), 32'(BUBBLE));
    chk("fl_valid", 32'(out_valid), 0); chk("fl_stall", 32'(stall_cnt), 3);
    cyc(0, 0, 1, 0, 1);
    chk("fl_after_occ", 32'(occupancy), 0);

    // freeze
    cyc(1, 16'h55, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 16'h77, 1, 1, 0);
      chk("frz_valid", 32'(out_valid), 0); chk("frz_rdy", 32'(in_ready), 0);
      chk("frz_occ", 32'(occupancy), 1); chk("frz_data", 32'(out_data), 16'h55);
      chk("frz_stall", 32'(stall_cnt), 3);
    end
    cyc(0, 0, 0, 0, 1);
    chk("thaw_valid", 32'(out_valid), 1); chk("thaw_data", 32'(out_data), 16'h55);
    chk("thaw_stall", 32'(stall_cnt), 4);

    // saturation
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1);
    chk("sat_14", 32'(stall_cnt), 14);
    cyc(0, 0, 0, 0, 1);
    chk("sat_15", 32'(stall_cnt), 15);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 1);
    chk("sat_hold", 32'(stall_cnt), 15);

    // reset mid-transfer
    cyc(1, 16'h66, 0, 0, 1);
    chk("mid_occ2", 32'(occupancy), 2);
    #1 reset = 1'b0;
    cyc(1, 16'h99, 1, 1, 1);
    chk("mid_rst_occ", 32'(occupancy), 0); chk("mid_rst_stall", 32'(stall_cnt), 0);
    chk("mid_rst_data", 32'(out_data), 32'(BUBBLE));
    #1 reset = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit iv, ordy, fl, de;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 9) < 6);
      fl   = ($urandom_range(0, 29) == 0);
      de   = ($urandom_range(0, 9) != 0);
      if (fl) ordy = 1'b1;
      #1 reset = ($urandom_range(0, 199) != 0);
      cyc(iv, 16'($urandom), ordy, fl, de);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
